uart_rx: RTL

UART 8N1 receiver with an output byte FIFO. It is the receiving end of the serial link that `riscv_top` drives on `Tx`. The block decodes that line back into bytes, so the simulation bench or host-side FPGA logic can capture program output. It oversamples the line with the system clock, takes one sample at mid-bit, and buffers decoded bytes for a simple pop-style reader.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_fifo.sv | 60 ++++++
 rtl/uart_rx.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings, data width and baud divisor macro.
// Defining UART_RX_PARITY_EN adds the PARITY state used by 8E1 framing.
`ifndef UART_PKG_SV
`define UART_PKG_SV

`define UART_CLKS_PER_BIT(clk_freq, baud_rate) ((clk_freq) / (baud_rate))

package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_t;

endpackage

`endif

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO with registered empty/full flags.
// A push into a full FIFO lands only when a pop happens on the same edge; otherwise it is dropped.
module uart_rx_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             drop
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = (DEPTH_LOG2 + 1)'(1);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic [DEPTH_LOG2:0] wr_next;
  logic [DEPTH_LOG2:0] rd_next;
  logic                do_push;
  logic                do_pop;

  // pop is a request that is honoured only while empty is low
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;

  assign wr_next = do_push ? wr_ptr + PTR_ONE : wr_ptr;
  assign rd_next = do_pop  ? rd_ptr + PTR_ONE : rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      if (do_push) begin
        mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
      end
      empty <= (wr_next == rd_next);
      full  <= (wr_next[DEPTH_LOG2] != rd_next[DEPTH_LOG2]) &&
               (wr_next[DEPTH_LOG2-1:0] == rd_next[DEPTH_LOG2-1:0]);
    end
  end

  assign dout = mem[rd_ptr[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM and FWFT byte FIFO.
// Default framing is 8N1; define UART_RX_PARITY_EN for 8E1 with a parity_err pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ        = 100_000_000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  input  logic                      rd_en,
  output logic [UART_DATA_BITS-1:0] dout,
  output logic                      empty,
  output logic                      full,
  output logic                      overrun,
  output logic                      frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                      parity_err
`endif
);

  // CLKS_PER_BIT must be at least 4 so the half-bit load stays positive
  localparam int CLKS_PER_BIT = `UART_CLKS_PER_BIT(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

  rx_state_t                 state;
  rx_state_t                 state_next;
  logic                      sync1;
  logic                      rx_s;
  logic [CNT_W-1:0]          cnt;
  logic                      tick;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      parity_ok;
  logic                      push;
  logic                      drop;
  logic                      frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic                      par_bit;
  logic                      parity_err_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  assign tick = (cnt == '0);

`ifdef UART_RX_PARITY_EN
  assign parity_ok = (par_bit == ^shift);
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!rx_s) state_next = START;
      START:     if (tick) state_next = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:      if (tick && bit_idx == LAST_BIT) state_next = PARITY;
      PARITY:    if (tick) state_next = STOP;
`else
      DATA:      if (tick && bit_idx == LAST_BIT) state_next = STOP;
`endif
      STOP:      if (tick) state_next = rx_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_s) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    push        = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d = 1'b0;
`endif
    if (state == STOP && tick) begin
      push        = rx_s && parity_ok;
      frame_err_d = !rx_s;
`ifdef UART_RX_PARITY_EN
      parity_err_d = !parity_ok;
`endif
    end
  end

  // The counter is reloaded every idle cycle so the half-bit delay is ready on the start edge
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      if (state == IDLE) begin
        cnt     <= HALF_LOAD;
        bit_idx <= '0;
      end else if (tick) begin
        cnt <= BIT_LOAD;
      end else begin
        cnt <= cnt - CNT_ONE;
      end
      if (state == DATA && tick) begin
        shift   <= {rx_s, shift[UART_DATA_BITS-1:1]};
        bit_idx <= bit_idx + 3'd1;
      end
`ifdef UART_RX_PARITY_EN
      if (state == PARITY && tick) begin
        par_bit <= rx_s;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      overrun   <= drop;
      frame_err <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      parity_err <= parity_err_d;
`endif
    end
  end

  uart_rx_fifo #(
    .WIDTH      (UART_DATA_BITS),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (shift),
    .pop   (rd_en),
    .dout  (dout),
    .empty (empty),
    .full  (full),
    .drop  (drop)
  );

endmodule
